pamp_sequencer: RTL
===================

# pamp_sequencer

Power-up/power-down sequencer for the PAMP grid (G1) and anode supplies. It sits directly downstream of the card-2 interlock logic: it consumes the G1 permission, G1 OK, anode permission and anode OK status, and it produces the G1/anode PS activation commands that card 2 monitors. It enforces the G1-before-anode ordering, per-step timeouts, a timed stop dwell and a latched first-fault code with operator acknowledge.

## Interface
- G1_TIMEOUT, 192: cycles allowed in G1_RAMP for G1 OK (3 s at 64 Hz).
- PERM_TIMEOUT, 128: cycles allowed in AN_PERM_WAIT for anode permission.
- AN_TIMEOUT, 320: cycles allowed in AN_RAMP for anode OK.
- STOP_DWELL, 64: cycles G1 stays on after the anode drops in STOPPING.
- clk  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  operator start; asynchronous; acted on the rising edge.
- i_stop  in  1  operator stop; asynchronous; level-sensitive.
- i_fault_ack  in  1  operator fault acknowledge; asynchronous; acted on the rising edge.
- i_not_g1_on_perm  in  1  1 means the G1 interlock is tripped; synchronous to clk.
- i_g1_ok  in  1  1 means the G1 supply is OK; synchronous.
- i_an_on_perm  in  1  1 means the anode is permitted; synchronous.
- i_an_ok  in  1  1 means the anode supply is OK; synchronous.
- o_g1_ps_act  out  1  G1 supply enable.
- o_an_ps_act  out  1  anode supply enable.
- o_ready  out  1  high in RUN only.
- o_fault  out  1  high in FAULT only.
- o_fault_code  out  3  latched first-fault cause; 0 means none.
- o_state  out  3  current state encoding.

## Operation
- Synchronizers:
  - i_start, i_stop and i_fault_ack each pass through a 2-flop synchronizer.
  - A rising-edge detector on synchronized start and ack compares the synchronized value with its one-cycle-delayed copy.
- States (encoding): IDLE 0, G1_RAMP 1, AN_PERM_WAIT 2, AN_RAMP 3, RUN 4, STOPPING 5, FAULT 6. Codes 7 and unreachable values go to FAULT with fault code 0.
- Outputs are decoded from the state register only (Moore):
  - G1 on in G1_RAMP through STOPPING.
  - Anode on in AN_RAMP and RUN.
- Transitions:
  - IDLE: start_edge & !stop_s & !i_not_g1_on_perm -> G1_RAMP. A start edge while tripped or while stopping is discarded.
  - G1_RAMP: i_g1_ok -> AN_PERM_WAIT. Timeout -> FAULT, code 1.
  - AN_PERM_WAIT: i_an_on_perm -> AN_RAMP. Timeout -> FAULT, code 2.
  - AN_RAMP: i_an_ok -> RUN. Timeout -> FAULT, code 3.
  - RUN: stays until a stop or a fault.
  - STOPPING: after STOP_DWELL cycles -> IDLE. Faults are still checked here.
  - FAULT: ack_edge & !i_not_g1_on_perm -> IDLE, fault code cleared to 0. Start edges are ignored in FAULT.
- Fault checks, applied in every state from G1_RAMP to STOPPING:
  - i_not_g1_on_perm -> code 4.
  - Loss of i_g1_ok in AN_PERM_WAIT, AN_RAMP or RUN -> code 5.
  - Loss of i_an_ok in RUN -> code 6.
  - Loss of i_an_on_perm in AN_RAMP or RUN -> code 7.
- Priority on any edge:
  - Fault beats stop, and stop beats progress or timeout.
  - Among simultaneous faults, the lowest code wins.
  - stop_s in G1_RAMP, AN_PERM_WAIT, AN_RAMP or RUN -> STOPPING.
- Fault code latching: the code is written only on entry to FAULT. The first cause is retained until ack.
- Timer:
  - Width is $clog2 of the largest parameter plus 1.
  - Cleared on every state change; increments while the state is held.
  - A timeout fires on the edge where timer == limit-1 and the awaited condition is false.
  - If the condition is true on that same edge, the transition succeeds.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0; o_state 0.
  - Timer, synchronizers and edge-detect flops 0.
- Start latency: i_start rising before edge k -> o_g1_ps_act high after edge k+2. Same latency for ack and stop.
- Interlock latency: a synchronous input asserted before edge k -> state and outputs updated after edge k (one cycle).
- Dwell: the anode drops one cycle after stop_s is seen. G1 drops exactly STOP_DWELL cycles after entering STOPPING.
- Reset asserted mid-sequence forces both enables low asynchronously, with no dwell.

## Structure
- Package pamp_pkg holds:
  - state_t enum (3-bit, encodings above).
  - fault_code_t enum: NONE 0, G1_TMO 1, PERM_TMO 2, AN_TMO 3, G1_TRIP 4, G1_LOST 5, AN_LOST 6, PERM_LOST 7.
- Sub-module pamp_sync2: a parameterless 2-flop synchronizer with async active-low reset. It is instantiated three times.
- Top level contains the FSM, the timer and the fault latch.

## Test plan
- Nominal sequence: start pulse; i_g1_ok at cycle 10; i_an_on_perm at 15; i_an_ok at 40 -> states 1,2,3,4; o_ready=1; both enables high; fault code 0.
- G1 timeout: start with i_g1_ok held 0 -> FAULT after exactly 192 cycles in G1_RAMP, code 1, enables 0. Then ack -> IDLE, code 0.
- Boundary: i_g1_ok rising on the timeout edge -> AN_PERM_WAIT, no fault.
- Stop from RUN: o_an_ps_act low 3 cycles after i_stop. o_g1_ps_act low 64 cycles after STOPPING entry. Then IDLE.
- Simultaneous faults: in RUN, drop i_g1_ok and i_an_ok on the same edge -> code 5. A later trip on i_not_g1_on_perm does not overwrite it. Ack while tripped is ignored; ack after the trip clears -> IDLE.
- Reset mid-AN_RAMP: assert reset between edges -> enables low immediately. After release: IDLE; a start edge restarts the sequence at G1_RAMP.

Source files
------------

// File: rtl/pamp_pkg.sv
// Shared types for the PAMP grid/anode power sequencer.
// State and fault-code encodings are visible on the o_state/o_fault_code ports.
package pamp_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      G1_RAMP      = 3'd1,
      AN_PERM_WAIT = 3'd2,
      AN_RAMP      = 3'd3,
      RUN          = 3'd4,
      STOPPING     = 3'd5,
      FAULT        = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      G1_TMO    = 3'd1,
      PERM_TMO  = 3'd2,
      AN_TMO    = 3'd3,
      G1_TRIP   = 3'd4,
      G1_LOST   = 3'd5,
      AN_LOST   = 3'd6,
      PERM_LOST = 3'd7
   } fault_code_t;

   localparam int DEF_G1_TIMEOUT   = 192;
   localparam int DEF_PERM_TIMEOUT = 128;
   localparam int DEF_AN_TIMEOUT   = 320;
   localparam int DEF_STOP_DWELL   = 64;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pamp_sync2.sv
// Two-flop synchronizer for one asynchronous operator input.
module pamp_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pamp_sequencer.sv
// PAMP G1/anode power sequencer: ordered ramp-up, step timeouts, timed stop dwell,
// and a first-fault latch released by operator acknowledge.
module pamp_sequencer
   import pamp_pkg::*;
#(
   parameter int G1_TIMEOUT   = DEF_G1_TIMEOUT,
   parameter int PERM_TIMEOUT = DEF_PERM_TIMEOUT,
   parameter int AN_TIMEOUT   = DEF_AN_TIMEOUT,
   parameter int STOP_DWELL   = DEF_STOP_DWELL
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_fault_ack,
   input  logic       i_not_g1_on_perm,
   input  logic       i_g1_ok,
   input  logic       i_an_on_perm,
   input  logic       i_an_ok,
   output logic       o_g1_ps_act,
   output logic       o_an_ps_act,
   output logic       o_ready,
   output logic       o_fault,
   output logic [2:0] o_fault_code,
   output logic [2:0] o_state
);

   localparam int TMR_W = $clog2(max4(G1_TIMEOUT, PERM_TIMEOUT, AN_TIMEOUT, STOP_DWELL)) + 1;

   state_t           r_state;
   state_t           w_next_state;
   fault_code_t      r_fault_code;
   fault_code_t      w_next_code;
   fault_code_t      w_live_fault;
   logic [TMR_W-1:0] r_timer;

   logic w_start_s;
   logic w_stop_s;
   logic w_ack_s;
   logic r_start_d;
   logic r_ack_d;
   logic w_start_edge;
   logic w_ack_edge;
   logic w_active;

   pamp_sync2 u_sync_start (.clk(clk), .reset(reset), .i_d(i_start),     .o_q(w_start_s));
   pamp_sync2 u_sync_stop  (.clk(clk), .reset(reset), .i_d(i_stop),      .o_q(w_stop_s));
   pamp_sync2 u_sync_ack   (.clk(clk), .reset(reset), .i_d(i_fault_ack), .o_q(w_ack_s));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start_d <= 1'b0;
         r_ack_d   <= 1'b0;
      end else begin
         r_start_d <= w_start_s;
         r_ack_d   <= w_ack_s;
      end
   end

   assign w_start_edge = w_start_s & ~r_start_d;
   assign w_ack_edge   = w_ack_s & ~r_ack_d;

   assign w_active = (r_state == G1_RAMP) || (r_state == AN_PERM_WAIT) ||
                     (r_state == AN_RAMP) || (r_state == RUN) || (r_state == STOPPING);

   // Interlock faults, lowest code first so simultaneous causes resolve deterministically.
   always_comb begin
      w_live_fault = NONE;
      if (w_active) begin
         if (i_not_g1_on_perm)
            w_live_fault = G1_TRIP;
         else if (!i_g1_ok && ((r_state == AN_PERM_WAIT) || (r_state == AN_RAMP) || (r_state == RUN)))
            w_live_fault = G1_LOST;
         else if (!i_an_ok && (r_state == RUN))
            w_live_fault = AN_LOST;
         else if (!i_an_on_perm && ((r_state == AN_RAMP) || (r_state == RUN)))
            w_live_fault = PERM_LOST;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Progress/timeout first, then stop and faults override in rising priority.
   always_comb begin
      w_next_state = r_state;
      w_next_code  = NONE;
      case (r_state)
         IDLE: begin
            if (w_start_edge && !w_stop_s && !i_not_g1_on_perm)
               w_next_state = G1_RAMP;
         end
         G1_RAMP: begin
            if (i_g1_ok) begin
               w_next_state = AN_PERM_WAIT;
            end else if (r_timer == TMR_W'(G1_TIMEOUT - 1)) begin
               w_next_state = FAULT;
               w_next_code  = G1_TMO;
            end
         end
         AN_PERM_WAIT: begin
            if (i_an_on_perm) begin
               w_next_state = AN_RAMP;
            end else if (r_timer == TMR_W'(PERM_TIMEOUT - 1)) begin
               w_next_state = FAULT;
               w_next_code  = PERM_TMO;
            end
         end
         AN_RAMP: begin
            if (i_an_ok) begin
               w_next_state = RUN;
            end else if (r_timer == TMR_W'(AN_TIMEOUT - 1)) begin
               w_next_state = FAULT;
               w_next_code  = AN_TMO;
            end
         end
         RUN: begin
            w_next_state = RUN;
         end
         STOPPING: begin
            if (r_timer == TMR_W'(STOP_DWELL - 1))
               w_next_state = IDLE;
         end
         FAULT: begin
            if (w_ack_edge && !i_not_g1_on_perm)
               w_next_state = IDLE;
         end
         default: begin
            w_next_state = FAULT;
            w_next_code  = NONE;
         end
      endcase

      if (w_active && w_stop_s && (r_state != STOPPING)) begin
         w_next_state = STOPPING;
         w_next_code  = NONE;
      end
      if (w_live_fault != NONE) begin
         w_next_state = FAULT;
         w_next_code  = w_live_fault;
      end
   end

   // Saturating so a long RUN/IDLE dwell can never alias back onto a limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_timer <= '0;
      else if (w_next_state != r_state)
         r_timer <= '0;
      else if (r_timer != '1)
         r_timer <= r_timer + TMR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_fault_code <= NONE;
      else if ((r_state != FAULT) && (w_next_state == FAULT))
         r_fault_code <= w_next_code;
      else if ((r_state == FAULT) && (w_next_state == IDLE))
         r_fault_code <= NONE;
   end

   always_comb begin
      o_g1_ps_act = 1'b0;
      o_an_ps_act = 1'b0;
      o_ready     = 1'b0;
      o_fault     = 1'b0;
      case (r_state)
         G1_RAMP, AN_PERM_WAIT, STOPPING: o_g1_ps_act = 1'b1;
         AN_RAMP: begin
            o_g1_ps_act = 1'b1;
            o_an_ps_act = 1'b1;
         end
         RUN: begin
            o_g1_ps_act = 1'b1;
            o_an_ps_act = 1'b1;
            o_ready     = 1'b1;
         end
         FAULT:   o_fault = 1'b1;
         default: o_fault = 1'b0;
      endcase
   end

   assign o_fault_code = r_fault_code;
   assign o_state      = r_state;

endmodule
